// File: rtl/simple_bus_master_arb.sv
// Round-robin arbiter that serializes client read/write requests onto one simple_bus.
// A saturating ready watchdog completes a stalled transaction with an error pulse.
module simple_bus_master_arb #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*2-1:0]      m_mode,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          req,
  input  logic                          gnt,
  output logic [ADDR_W-1:0]             addr,
  output logic [1:0]                    mode,
  output logic [DATA_W-1:0]             wdata,
  output logic                          start,
  input  logic                          rdy,
  input  logic [DATA_W-1:0]             rdata
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, START, WAIT, DONE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [CW-1:0] cnt;

  logic          any_req;
  logic [IW-1:0] win;
  int            idx;

  // Lowest requesting index at or after ptr, wrapping around.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!any_req && m_req[idx]) begin
        any_req = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      m_gnt   <= '0;
      m_done  <= '0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      req     <= 1'b0;
      addr    <= '0;
      mode    <= '0;
      wdata   <= '0;
      start   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= win;
            addr       <= m_addr[int'(win)*ADDR_W +: ADDR_W];
            mode       <= m_mode[int'(win)*2 +: 2];
            wdata      <= m_wdata[int'(win)*DATA_W +: DATA_W];
            req        <= 1'b1;
            m_gnt      <= '0;
            m_gnt[win] <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (gnt) begin
            start <= 1'b1;
            state <= START;
          end
        end
        START: begin
          start <= 1'b0;
          cnt   <= '0;
          if (rdy) begin
            m_rdata       <= rdata;
            m_err         <= 1'b0;
            m_done[owner] <= 1'b1;
            req           <= 1'b0;
            state         <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // rdy takes priority over a watchdog expiry in the same cycle.
          if (rdy) begin
            m_rdata       <= rdata;
            m_err         <= 1'b0;
            m_done[owner] <= 1'b1;
            req           <= 1'b0;
            state         <= DONE;
          end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
            m_rdata       <= '0;
            m_err         <= 1'b1;
            m_done[owner] <= 1'b1;
            req           <= 1'b0;
            state         <= DONE;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          m_done <= '0;
          m_err  <= 1'b0;
          m_gnt  <= '0;
          ptr    <= (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/simple_bus_master_arb.md
# simple_bus_master_arb

Round-robin arbiter and transaction sequencer upstream of the simple_bus memory-side module. Accepts read/write requests from up to NUM_MASTERS CPU-side clients, serializes them onto the single shared simple_bus (req/gnt/addr/data/mode/start/rdy), and returns completion status and read data to the owning client. It adds a ready watchdog so that a non-responding memory cannot hang the bus.

## Interface
Parameters:
- NUM_MASTERS, 4: number of clients; 2..8.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- TIMEOUT, 15: maximum cycles to wait for rdy after start; 0 disables the watchdog.

Ports (clk and rst are the single clock and its reset; reset is asynchronous and active-high):
- clk  in  1  bus clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- m_req  in  NUM_MASTERS  per-client request; held high until that client's m_done.
- m_addr  in  NUM_MASTERS*ADDR_W  per-client address, packed; client i at [i*ADDR_W +: ADDR_W].
- m_mode  in  NUM_MASTERS*2  per-client mode: 2'b00 is read, 2'b01 is write, others are reserved and passed through.
- m_wdata  in  NUM_MASTERS*DATA_W  per-client write data, packed.
- m_gnt  out  NUM_MASTERS  one-hot owner indication.
- m_done  out  NUM_MASTERS  one-cycle completion pulse to the owner.
- m_err  out  1  one-cycle pulse, coincident with m_done, when the transaction timed out.
- m_rdata  out  DATA_W  read data; valid in the m_done cycle.
- req  out  1  bus request to memory side.
- gnt  in  1  bus grant from memory side.
- addr  out  ADDR_W  latched transaction address.
- mode  out  2  latched transaction mode.
- wdata  out  DATA_W  latched write data.
- start  out  1  one-cycle transaction start strobe.
- rdy  in  1  memory-side completion.
- rdata  in  DATA_W  memory-side read data; sampled when rdy is high.

## Operation
- FSM states: IDLE, REQ, START, WAIT, DONE.
- **IDLE:**
  - If any m_req is high, select the winner by round-robin: search starts at ptr, and the lowest index at or after ptr (wrapping) wins.
  - Latch the winner index as owner, plus its addr, mode and wdata. Go to REQ.
  - If no m_req is high, stay in IDLE.
- **REQ:** req=1 and m_gnt[owner]=1. When gnt=1, go to START. There is no limit on how long the bus waits for gnt.
- **START:**
  - start=1 for exactly this cycle; req stays 1. Clear the watchdog counter.
  - If rdy=1 in this cycle, capture rdata and go to DONE. Otherwise go to WAIT.
- **WAIT:** req=1 and the counter increments each cycle.
  - If rdy=1, capture rdata and go to DONE.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT, set the error flag, force the captured data to 0, and go to DONE.
- **DONE:**
  - m_done[owner]=1, with m_err equal to the error flag. req=0.
  - Set ptr to owner+1, wrapping modulo NUM_MASTERS. Go to IDLE.
- addr, mode and wdata stay stable from REQ through DONE. m_gnt is high from REQ through DONE.
- If the owner drops m_req mid-transaction, it is ignored: the transaction completes and m_done is still pulsed.
- Other clients' m_req are not sampled outside IDLE.
- gnt dropping after START is ignored.
- rdy is ignored in IDLE, REQ and DONE.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates; it cannot wrap.

## Timing
- **Reset:** state=IDLE, ptr=0, owner=0, counter=0. Every output is 0: req, start, m_gnt, m_done, m_err, m_rdata, addr, mode and wdata.
- **Reset mid-transaction:** the transaction is abandoned with no m_done. The first arbitration after reset starts at ptr=0.
- **Latency,** with m_req first seen high in IDLE at cycle t:
  - req rises at t+1.
  - If gnt is seen at cycle g, start is high at g+1.
  - If rdy is seen at cycle r, m_done and m_rdata appear at r+1.
- **Minimum transaction:** m_req at t, gnt at t+1, rdy at t+2 (in START), m_done at t+3. The next arbitration happens at t+4.
- **Timeout:**
  - Start is high at s. With no rdy, m_done and m_err pulse at s+TIMEOUT+2, and m_rdata=0.
  - If rdy and the timeout condition coincide, rdy wins and m_err=0.
- Back-to-back transactions leave at least one IDLE cycle with req=0 between them.

## Test plan
- **Single read:** client 2 requests addr=0x3C with mode=00. gnt is held high, and rdy is given 2 cycles after start with rdata=0xA5. Required: start is a single-cycle pulse, addr=0x3C, m_done[2] at rdy+1 with m_rdata=0xA5, m_err=0.
- **Round-robin:** all 4 clients hold m_req and rdy is immediate. Required: grant order 0,1,2,3,0. Each m_gnt is one-hot, with exactly one m_done per transaction.
- **Timeout:** TIMEOUT=15, rdy is never asserted. Required: m_done and m_err at start+17, m_rdata=0, req=0 the following cycle, and the bus recovers on the next request.
- **Delayed gnt:** gnt is withheld for 20 cycles. Required: req is held and start is not asserted until the cycle after gnt. Write data 0x5A is stable on wdata throughout.
- **Rdy in START and coincident timeout:**
  - rdy asserted in the start cycle gives m_done one cycle later.
  - With TIMEOUT=3 and rdy at the limit cycle, m_err=0.
- **Async reset:** assert rst during WAIT. Required: all outputs go to 0 immediately with no m_done. After release, client 0 wins even if ptr was previously 2.
